// File: rtl/loadable_down_timer.sv
// Loadable down-counting timer: counts a reload value down to zero and pulses tc,
// either once (one-shot) or repeatedly with automatic reload (periodic).
module loadable_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;
  logic             busy_reg, done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= ZERO;
      reload_reg <= ZERO;
      tc_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
      busy_reg   <= (state_next == ST_RUN);
      done_reg   <= (state_next == ST_EXPIRED);
    end
  end

  // Edge priority: load, then stop, then start, then the countdown itself.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;

    if (load) begin
      reload_next = din;
      count_next  = din;
      if ((din == ZERO) || stop) begin
        state_next = ST_IDLE;
      end else begin
        case (state_reg)
          ST_EXPIRED: state_next = ST_IDLE;
          ST_IDLE:    state_next = start ? ST_RUN : ST_IDLE;
          default:    state_next = state_reg;
        endcase
      end
    end else if (stop) begin
      state_next = ST_IDLE;
    end else if (start) begin
      // A zero reload value would expire instantly, so start is ignored then.
      if (reload_reg != ZERO) begin
        count_next = reload_reg;
        state_next = ST_RUN;
      end
    end else if (state_reg == ST_RUN) begin
      if (count_reg == ZERO) begin
        count_next = reload_reg;
      end else if (count_reg == ONE) begin
        count_next = ZERO;
        tc_next    = 1'b1;
        state_next = mode ? ST_RUN : ST_EXPIRED;
      end else begin
        count_next = count_reg - ONE;
      end
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_loadable_down_timer.sv
// Directed bench for loadable_down_timer: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_loadable_down_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  loadable_down_timer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .count (count),
    .tc    (tc),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int t, input int b, input int d);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".tc"},    32'(tc),    t);
    chk({tag, ".busy"},  32'(busy),  b);
    chk({tag, ".done"},  32'(done),  d);
    $display("step %-10s count=%0d tc=%0d busy=%0d done=%0d", tag, count, tc, busy, done);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int seq2 [8];
    seq2 = '{2, 1, 0, 3, 2, 1, 0, 3};
    rst = 1'b0; din = 4'd0; mode = 1'b0;
    idle_inputs();

    // 1: reset, one-shot countdown from 5
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b1;
    load = 1'b1; din = 4'd5;
    tick(); idle_inputs();
    chk_all("t1.load", 5, 0, 0, 0);
    start = 1'b1;
    tick(); idle_inputs();
    chk_all("t1.start", 5, 0, 1, 0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_all("t1.run", i, 0, 1, 0);
    end
    tick();
    chk_all("t1.tc", 0, 1, 0, 1);
    tick();
    chk_all("t1.hold", 0, 0, 0, 1);

    // 2: periodic reload of 3
    mode = 1'b1;
    load = 1'b1; din = 4'd3;
    tick(); idle_inputs();
    chk_all("t2.load", 3, 0, 0, 0);
    start = 1'b1;
    tick(); idle_inputs();
    chk_all("t2.start", 3, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("t2.run", seq2[i], (seq2[i] == 0) ? 1 : 0, 1, 0);
    end

    // 3: reload on the fly, stop at 6, restart reloads 9
    mode = 1'b0;
    load = 1'b1; din = 4'd9;
    tick(); idle_inputs();
    chk_all("t3.load", 9, 0, 1, 0);
    for (int i = 8; i >= 6; i--) begin
      tick();
      chk_all("t3.run", i, 0, 1, 0);
    end
    stop = 1'b1;
    tick(); idle_inputs();
    chk_all("t3.stop", 6, 0, 0, 0);
    tick();
    chk_all("t3.idle", 6, 0, 0, 0);
    start = 1'b1;
    tick(); idle_inputs();
    chk_all("t3.restart", 9, 0, 1, 0);
    for (int i = 8; i >= 1; i--) begin
      tick();
      chk_all("t3.run2", i, 0, 1, 0);
    end
    tick();
    chk_all("t3.tc", 0, 1, 0, 1);

    // 4: load while running
    start = 1'b1;
    tick(); idle_inputs();
    chk_all("t4.start", 9, 0, 1, 0);
    for (int i = 8; i >= 4; i--) begin
      tick();
      chk_all("t4.run", i, 0, 1, 0);
    end
    load = 1'b1; din = 4'd2;
    tick(); idle_inputs();
    chk_all("t4.load2", 2, 0, 1, 0);
    tick();
    chk_all("t4.run1", 1, 0, 1, 0);
    tick();
    chk_all("t4.tc", 0, 1, 0, 1);
    start = 1'b1;
    tick(); idle_inputs();
    chk_all("t4.start2", 2, 0, 1, 0);
    load = 1'b1; din = 4'd0;
    tick(); idle_inputs();
    chk_all("t4.load0", 0, 0, 0, 0);
    tick();
    chk_all("t4.idle", 0, 0, 0, 0);

    // 5: zero-reload start, load+start, load+stop
    start = 1'b1;
    tick(); idle_inputs();
    chk_all("t5.start0", 0, 0, 0, 0);
    load = 1'b1; din = 4'd7; start = 1'b1;
    tick(); idle_inputs();
    chk_all("t5.ldstart", 7, 0, 1, 0);
    tick();
    chk_all("t5.run", 6, 0, 1, 0);
    load = 1'b1; din = 4'd4; stop = 1'b1;
    tick(); idle_inputs();
    chk_all("t5.ldstop", 4, 0, 0, 0);
    tick();
    chk_all("t5.idle", 4, 0, 0, 0);

    // Periodic with reload 1 toggles 1,0 with tc every second cycle
    mode = 1'b1;
    load = 1'b1; din = 4'd1; start = 1'b1;
    tick(); idle_inputs();
    chk_all("r1.start", 1, 0, 1, 0);
    tick();
    chk_all("r1.a", 0, 1, 1, 0);
    tick();
    chk_all("r1.b", 1, 0, 1, 0);
    tick();
    chk_all("r1.c", 0, 1, 1, 0);
    stop = 1'b1;
    tick(); idle_inputs();
    chk_all("r1.stop", 0, 0, 0, 0);
    mode = 1'b0;

    // 6: asynchronous reset mid-count
    load = 1'b1; din = 4'd4; start = 1'b1;
    tick(); idle_inputs();
    chk_all("t6.start", 4, 0, 1, 0);
    tick();
    chk_all("t6.run", 3, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk_all("t6.arst", 0, 0, 0, 0);
    #2 rst = 1'b1;
    start = 1'b1;
    tick(); idle_inputs();
    chk_all("t6.start0", 0, 0, 0, 0);
    tick();
    chk_all("t6.idle", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
